// File: rtl/rv_muldiv_seq.sv
// Sequential RV32M multiply/divide unit: one bit retired per cycle, signs fixed up in a final stage.
// Optional divider is enabled by defining RV_MULDIV_DIV_EN; without it divide ops finish early with result 0.
module rv_muldiv_seq #(
    parameter int DPWIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [DPWIDTH-1:0] rs1,
    input  logic [DPWIDTH-1:0] rs2,
    output logic               busy,
    output logic               done,
    output logic [DPWIDTH-1:0] result
);

    localparam int W  = DPWIDTH;
    localparam int CW = $clog2(DPWIDTH);

    localparam logic [W-1:0]   ONE_W  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [2*W-1:0] ONE_2W = {{(2*W-1){1'b0}}, 1'b1};

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2
    } state_t;

    function automatic logic [W-1:0] neg_w(input logic [W-1:0] v, input logic n);
        if (n) begin
            return ~v + ONE_W;
        end else begin
            return v;
        end
    endfunction

    function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v, input logic n);
        if (n) begin
            return ~v + ONE_2W;
        end else begin
            return v;
        end
    endfunction

    state_t         state_r;
    state_t         state_next_s;
    logic [2:0]     op_r;
    logic [W-1:0]   mag_a_r;
    logic [W-1:0]   mag_b_r;
    logic           sa_r;
    logic           sb_r;
    logic [2*W:0]   acc_r;
    logic [CW-1:0]  cnt_r;
    logic           busy_r;
    logic           done_r;
    logic [W-1:0]   result_r;

    logic           signed_a_s;
    logic           signed_b_s;
    logic           sa_s;
    logic           sb_s;
    logic [W-1:0]   mag_a_s;
    logic [W-1:0]   mag_b_s;
    logic [W:0]     mul_add_s;
    logic [W:0]     mul_sum_s;
    logic [2*W:0]   acc_step_s;
    logic [W-1:0]   mag_a_step_s;
    logic [W-1:0]   mag_b_step_s;
    logic [2*W-1:0] prod_s;
    logic [W-1:0]   res_s;

`ifdef RV_MULDIV_DIV_EN
    logic [W-1:0]   rs1_r;
    logic           div0_r;
    logic [W:0]     div_trial_s;
    logic [W+1:0]   div_diff_s;
    logic [W:0]     div_rem_s;
`endif

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

    // Operand sign decode and magnitude extraction for the incoming request
    always_comb begin
        signed_a_s = 1'b0;
        signed_b_s = 1'b0;
        case (op)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                signed_a_s = 1'b1;
                signed_b_s = 1'b1;
            end
            OP_MULHSU: begin
                signed_a_s = 1'b1;
                signed_b_s = 1'b0;
            end
            default: begin
                signed_a_s = 1'b0;
                signed_b_s = 1'b0;
            end
        endcase
        sa_s    = signed_a_s & rs1[W-1];
        sb_s    = signed_b_s & rs2[W-1];
        mag_a_s = neg_w(rs1, sa_s);
        mag_b_s = neg_w(rs2, sb_s);
    end

    // Next-state logic for the IDLE/RUN/SIGN sequencer
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
`ifdef RV_MULDIV_DIV_EN
                    state_next_s = RUN;
`else
                    state_next_s = op[2] ? SIGN : RUN;
`endif
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == CW'(W - 1)) begin
                    state_next_s = SIGN;
                end else begin
                    state_next_s = RUN;
                end
            end
            SIGN:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // One iteration of shift-add multiply or restoring divide
    always_comb begin
        // Multiply: right-shifting accumulator, top bit holds the add carry
        mul_add_s    = mag_b_r[0] ? {1'b0, mag_a_r} : '0;
        mul_sum_s    = acc_r[2*W:W] + mul_add_s;
        acc_step_s   = {1'b0, mul_sum_s, acc_r[W-1:1]};
        mag_a_step_s = mag_a_r;
        mag_b_step_s = {1'b0, mag_b_r[W-1:1]};
`ifdef RV_MULDIV_DIV_EN
        // Divide: remainder in the upper W+1 bits, quotient bits shift in at the bottom
        div_trial_s = {acc_r[2*W-1:W], mag_a_r[W-1]};
        div_diff_s  = {1'b0, div_trial_s} - {2'b00, mag_b_r};
        div_rem_s   = div_diff_s[W+1] ? div_trial_s : div_diff_s[W:0];
        if (op_r[2]) begin
            acc_step_s   = {div_rem_s, acc_r[W-2:0], ~div_diff_s[W+1]};
            mag_a_step_s = {mag_a_r[W-2:0], 1'b0};
            mag_b_step_s = mag_b_r;
        end else begin
            acc_step_s   = {1'b0, mul_sum_s, acc_r[W-1:1]};
            mag_a_step_s = mag_a_r;
            mag_b_step_s = {1'b0, mag_b_r[W-1:1]};
        end
`endif
    end

    // Sign correction and result selection in the SIGN stage
    always_comb begin
        prod_s = neg_2w(acc_r[2*W-1:0], sa_r ^ sb_r);
        res_s  = '0;
        case (op_r)
            OP_MUL:                         res_s = prod_s[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:   res_s = prod_s[2*W-1:W];
`ifdef RV_MULDIV_DIV_EN
            // Signed overflow needs no special case: |min|/1 negated wraps back to min, remainder 0
            OP_DIV, OP_DIVU: res_s = div0_r ? '1 : neg_w(acc_r[W-1:0], sa_r ^ sb_r);
            OP_REM, OP_REMU: res_s = div0_r ? rs1_r : neg_w(acc_r[2*W-1:W], sa_r);
`endif
            default: res_s = '0;
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            op_r     <= 3'b000;
            mag_a_r  <= '0;
            mag_b_r  <= '0;
            sa_r     <= 1'b0;
            sb_r     <= 1'b0;
            acc_r    <= '0;
            cnt_r    <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= '0;
`ifdef RV_MULDIV_DIV_EN
            rs1_r    <= '0;
            div0_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != IDLE);
            done_r  <= (state_r == SIGN);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        op_r    <= op;
                        mag_a_r <= mag_a_s;
                        mag_b_r <= mag_b_s;
                        sa_r    <= sa_s;
                        sb_r    <= sb_s;
                        acc_r   <= '0;
                        cnt_r   <= '0;
`ifdef RV_MULDIV_DIV_EN
                        rs1_r   <= rs1;
                        div0_r  <= (rs2 == '0);
`endif
                    end
                end
                RUN: begin
                    acc_r   <= acc_step_s;
                    mag_a_r <= mag_a_step_s;
                    mag_b_r <= mag_b_step_s;
                    cnt_r   <= cnt_r + CW'(1);
                end
                SIGN: begin
                    result_r <= res_s;
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_muldiv_seq.sv
// Scoreboard bench for rv_muldiv_seq (DPWIDTH=32): directed RV32M cases plus random ops against an arithmetic model.
module tb_rv_muldiv_seq;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    op;
    logic [W-1:0]  rs1;
    logic [W-1:0]  rs2;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;

    typedef struct {
        logic [W-1:0] res;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    rv_muldiv_seq #(.DPWIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rs1    (rs1),
        .rs2    (rs2),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference model straight from the RV32M definitions
    function automatic logic [W-1:0] ref_res(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [63:0] sp;
        logic [63:0]        up;
        int                 sa;
        int                 sb;
        sa = a;
        sb = b;
        case (o)
            3'd0: return a * b;
            3'd1: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return sp[63:32]; end
            3'd2: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); return sp[63:32]; end
            3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
`ifdef RV_MULDIV_DIV_EN
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
            3'd7: return (b == 32'd0) ? a : a % b;
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] o);
`ifdef RV_MULDIV_DIV_EN
        return LAT;
`else
        return o[2] ? 2 : LAT;
`endif
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Issue in the current cycle, finish in the expected done cycle; poke>0 re-pulses start mid-operation
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input int poke);
        int   lat;
        exp_t e;
        lat   = ref_lat(o);
        start = 1'b1;
        op    = o;
        rs1   = a;
        rs2   = b;
        e.res = ref_res(o, a, b);
        e.cyc = cyc + lat;
        exp_q.push_back(e);
        for (int i = 1; i <= lat; i++) begin
            @(posedge clk);
            #1;
            start = (i == poke);
            op    = 3'($urandom);
            rs1   = $urandom;
            rs2   = $urandom;
            if (i == 1 || i == lat - 1) chk("busy_during_op", {31'd0, busy}, 32'd1);
        end
        start = 1'b0;
    endtask

    // Monitor: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=done expected=no_done (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("result", result, e.res);
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                chk("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    initial begin
        int k;
        logic [2:0] rop;
        rst   = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        rs1   = '0;
        rs2   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed multiply and divide cases, issued back to back in each done cycle
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd5, 32'd100, 32'd7, 0);
        run_op(3'd7, 32'd100, 32'd7, 0);
        run_op(3'd4, 32'd5, 32'd0, 0);
        run_op(3'd6, 32'hFFFF_FFFB, 32'd0, 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'd0, 32'd7, 32'd6, 0);

        // start while busy must be ignored
        run_op(3'd0, 32'd3, 32'd4, 10);

        // Reset in cycle 10 of a long operation: no done, result cleared
`ifdef RV_MULDIV_DIV_EN
        rop = 3'd4;
`else
        rop = 3'd1;
`endif
        start = 1'b1;
        op    = rop;
        rs1   = 32'd1000;
        rs2   = 32'd3;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_result", result, 32'd0);
        chk("rst_mid_done", {31'd0, done}, 32'd0);
        repeat (LAT + 4) @(posedge clk);
        #1;

        // Random operations with occasional idle gaps
        for (int n = 0; n < 60; n++) begin
            k = $urandom_range(0, 3);
            if (k == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            run_op(3'($urandom), pick_operand(), pick_operand(), 0);
        end

        for (int i = 0; i < 4 * LAT && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_done actual=%0d_pending expected=0_pending", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
